// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boot_pkg;

   typedef enum logic [2:0] {
      LEN   = 3'd0,
      DATA  = 3'd1,
      WRITE = 3'd2,
      RUN   = 3'd3,
      ERROR = 3'd4
   } boot_state_t;

   localparam int WORD_BYTES = 4;
   localparam int LEN_BYTES  = 4;

endpackage

// File: rtl/boot_loader_byte_assembler.sv
// Packs a byte stream into 32-bit little-endian words (first byte -> bits [7:0]).
// Latency: word_done_o/word_o are combinational in the cycle of the 4th byte.
// Backpressure: none; every strobed byte is taken.
module byte_assembler (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        clear_i,
   input  logic        byte_vld_i,
   input  logic [7:0]  byte_dat_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);
   import boot_pkg::*;

   localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

   // Only the first three bytes need storage; the 4th is taken straight from the input.
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] bytes_q, bytes_d;

   // Next-state: shift each new byte in from the top, clear restarts the word.
   always_comb begin
      cnt_d   = cnt_q;
      bytes_d = bytes_q;
      if (clear_i) begin
         cnt_d   = '0;
         bytes_d = '0;
      end else if (byte_vld_i) begin
         cnt_d   = cnt_q + 2'd1;
         bytes_d = {byte_dat_i, bytes_q[23:8]};
      end
   end

   // Byte counter and partial-word registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt_q   <= '0;
         bytes_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         bytes_q <= bytes_d;
      end
   end

   assign word_o      = {byte_dat_i, bytes_q};
   assign word_done_o = byte_vld_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed image from a byte stream into RAM, then hands the RAM port to the CPU.
// Latency: RAM write the cycle after a word's 4th byte; CPU released the cycle after the last write.
// Backpressure: none; bytes are accepted every cycle in LEN/DATA/WRITE and ignored otherwise.
module boot_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        cpu_memwrite,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wd,
   output logic        ram_memwrite,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wd,
   output logic        cpu_reset,
   output logic        busy,
   output logic        error
);
   import boot_pkg::*;

   localparam int          IDX_W = $clog2(MAX_WORDS + 1);
   localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

   boot_state_t      state_q, state_d;
   logic [31:0]      n_q, n_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wd_q, wd_d;

   logic        loading;
   logic        byte_vld;
   logic        asm_clear;
   logic        word_done;
   logic [31:0] asm_word;
   logic [31:0] idx_ext;
   logic        last_word;

   assign loading   = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE);
   assign byte_vld  = rx_valid && loading;
   assign asm_clear = (state_q == LEN) && (state_d == DATA);
   assign idx_ext   = 32'(idx_q);
   assign last_word = ((idx_ext + 32'd1) == n_q);

   byte_assembler u_asm (
      .clk         (clk),
      .n_reset     (n_reset),
      .clear_i     (asm_clear),
      .byte_vld_i  (byte_vld),
      .byte_dat_i  (rx_data),
      .word_o      (asm_word),
      .word_done_o (word_done)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= LEN;
         n_q     <= '0;
         idx_q   <= '0;
         addr_q  <= BASE_ADDR;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
      end
   end

   // Next-state logic: length check, per-word write, and terminal RUN/ERROR.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LEN: begin
            if (word_done) begin
               if (asm_word > MAX_N)       state_d = ERROR;
               else if (asm_word == 32'd0) state_d = RUN;
               else                        state_d = DATA;
            end
         end
         DATA:    if (word_done) state_d = WRITE;
         WRITE:   state_d = last_word ? RUN : DATA;
         RUN:     state_d = RUN;
         ERROR:   state_d = ERROR;
         default: state_d = ERROR;
      endcase
   end

   // Datapath: capture N, latch the completed word and its address, advance idx on each write.
   always_comb begin
      n_d    = n_q;
      idx_d  = idx_q;
      addr_d = addr_q;
      wd_d   = wd_q;
      if ((state_q == LEN) && word_done) begin
         n_d = asm_word;
      end
      if ((state_q == DATA) && word_done) begin
         wd_d   = asm_word;
         addr_d = BASE_ADDR + idx_ext * 32'(WORD_BYTES);
      end
      if (state_q == WRITE) begin
         idx_d = idx_q + 1'b1;
      end
   end

   // Outputs: RAM port is a zero-latency pass-through of the CPU only in RUN.
   always_comb begin
      ram_memwrite = 1'b0;
      ram_addr     = addr_q;
      ram_wd       = wd_q;
      cpu_reset    = 1'b1;
      busy         = loading;
      error        = 1'b0;
      unique case (state_q)
         WRITE: ram_memwrite = 1'b1;
         RUN: begin
            ram_memwrite = cpu_memwrite;
            ram_addr     = cpu_addr;
            ram_wd       = cpu_wd;
            cpu_reset    = 1'b0;
         end
         ERROR:   error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Boot-time controller that owns the single RAM port between the CPU core and the RAM. After reset it holds the CPU in reset and receives a program image as a byte stream from a UART receiver. It assembles the bytes into 32-bit words and writes them into RAM. Once the last word is written, it releases the CPU and hands the RAM port to it as a pure pass-through.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word
- MAX_WORDS, 1024, largest accepted image length in words

- clk  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- cpu_memwrite  in  1  CPU store strobe
- cpu_addr  in  32  CPU byte address
- cpu_wd  in  32  CPU write data
- ram_memwrite  out  1  RAM write enable
- ram_addr  out  32  RAM byte address
- ram_wd  out  32  RAM write data
- cpu_reset  out  1  active-high reset to the CPU core
- busy  out  1  load in progress
- error  out  1  image rejected, sticky until reset

RAM read data goes from RAM to CPU directly and does not pass through this block.

## Operation
- Image format:
  - 4-byte little-endian word count N.
  - N words, 4 bytes each, little-endian (first byte is bits [7:0]).
- States:
  - LEN: collect 4 count bytes. After the 4th byte:
    - N > MAX_WORDS: go to ERROR.
    - N == 0: go to RUN.
    - Otherwise: go to DATA.
  - DATA: collect 4 bytes into a word. After the 4th byte, latch the word into ram_wd and ram_addr = BASE_ADDR + 4*idx, then go to WRITE.
  - WRITE: one cycle with ram_memwrite=1; idx increments.
    - If idx+1 == N: go to RUN.
    - Otherwise: go back to DATA.
  - RUN: ram_memwrite/ram_addr/ram_wd = cpu_memwrite/cpu_addr/cpu_wd, combinationally. cpu_reset=0. rx_valid is ignored.
  - ERROR: error=1, cpu_reset=1, ram_memwrite=0. rx_valid is ignored.
- rx_valid arriving during WRITE is accepted as byte 0 of the next word. No byte is ever dropped in LEN, DATA or WRITE.
- The N comparison is a full 32-bit unsigned compare. idx is $clog2(MAX_WORDS+1) bits wide and cannot wrap, because N ≤ MAX_WORDS.
- Outside RUN, cpu_* inputs are ignored.
- busy=1 in LEN, DATA and WRITE; 0 in RUN and ERROR.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - state=LEN, cpu_reset=1, busy=1, error=0.
  - ram_memwrite=0, ram_addr=BASE_ADDR, ram_wd=0.
  - idx=0, byte count=0, N=0.
- Write latency: the cycle after the rx_valid of a word's 4th byte, ram_memwrite=1 with address and data stable for that cycle.
- Release latency: cpu_reset falls on the cycle after the final WRITE cycle. For N=0, it falls on the cycle after the 4th count byte.
- Error: error rises on the cycle after the 4th count byte.
- Back-to-back bytes (rx_valid high every cycle) must load correctly.
- In RUN, ram_* outputs are combinational from cpu_*, with zero latency.
- n_reset asserted mid-load aborts the load:
  - All counters clear.
  - The next image is written starting again at BASE_ADDR.
  - Words already written stay in RAM.
  - The CPU stays in reset throughout.

## Structure
- Package boot_pkg:
  - boot_state_t enum {LEN, DATA, WRITE, RUN, ERROR}.
  - Constants WORD_BYTES=4 and LEN_BYTES=4.
- One sub-module, byte_assembler:
  - Shifts rx_data into a 32-bit little-endian word.
  - Has a 2-bit byte counter and pulses word_done on the 4th byte.
  - Has a clear input, used on each state change from LEN to DATA.
- boot_loader keeps the FSM, N, idx, the address/data output registers and the RUN pass-through mux.

## Test plan
- Reset: hold n_reset=0 -> cpu_reset=1, busy=1, error=0, ram_memwrite=0, ram_addr=0.
- Load N=2 with bytes 02 00 00 00 78 56 34 12 EF BE AD DE, rx_valid on every cycle -> writes (0x0, 0x12345678) then (0x4, 0xDEADBEEF), each a single-cycle ram_memwrite; cpu_reset=0 and busy=0 on the cycle after the second write.
- N=0 (00 00 00 00) -> no write; cpu_reset falls on the cycle after the 4th byte.
- N=MAX_WORDS+1 (01 04 00 00 for 1024) -> error=1, busy=0, no write; later rx bytes ignored; cpu_reset stays 1.
- In RUN, drive cpu_memwrite=1, cpu_addr=0x10, cpu_wd=0xA5 and pulse rx_valid -> ram outputs equal the CPU values in the same cycle; state is unchanged.
- Assert n_reset after 6 bytes of an N=2 image, then send a fresh N=1 image -> the single write goes to BASE_ADDR and the CPU is released afterwards.
